// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
// Default geometry and the pipeline stage-count derivation.
package cla_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  function automatic int cla_stages(
    input int width,
    input int block
  );
    return width / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group.
// Also exposes the carry into the group MSB for overflow detection.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a_i,
  input  logic [BLOCK-1:0] b_i,
  input  logic             cin_i,
  output logic [BLOCK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  // Flat lookahead: carry into bit i+1 from g/p/cin only.
  function automatic logic carry_at(
    input logic [BLOCK-1:0] gv,
    input logic [BLOCK-1:0] pv,
    input logic             ci,
    input int               i
  );
    logic acc;
    logic run;
    acc = 1'b0;
    run = 1'b1;
    for (int j = BLOCK - 1; j >= 0; j--) begin
      if (j <= i) begin
        acc = acc | (run & gv[j]);
        run = run & pv[j];
      end
    end
    return acc | (run & ci);
  endfunction

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = carry_at(g, p, cin_i, i);
    end
  end

  assign sum_o  = p ^ c[BLOCK-1:0];
  assign cout_o = c[BLOCK];
  assign cmsb_o = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one BLOCK-bit group per stage.
// Global-enable valid/ready pipeline with output backpressure.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic             InputCarry,
  input  logic             Subtract,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Sum,
  output logic             OutputCarry,
  output logic             Overflow
);

  localparam int S = cla_stages(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0 || WIDTH < BLOCK) begin : g_bad_geom
    $error("WIDTH must be a non-zero multiple of BLOCK");
  end

  typedef struct packed {
    logic             v;
    logic             c;
    logic             ovf;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t q [S];
  stage_t in_s;
  logic   adv;

  assign adv     = !q[S-1].v | OutReady;
  assign InReady = adv;

  always_comb begin
    in_s     = '0;
    in_s.v   = InValid;
    in_s.a   = InputA;
    in_s.b   = Subtract ? ~InputB : InputB;
    in_s.c   = Subtract ^ InputCarry;
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    stage_t           src;
    stage_t           d;
    stage_t           r;
    logic [BLOCK-1:0] gsum;
    logic             gco;
    logic             gcm;

    if (k == 0) begin : g_first
      assign src = in_s;
    end else begin : g_next
      assign src = q[k-1];
    end

    cla_block #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a_i   (src.a[k*BLOCK +: BLOCK]),
      .b_i   (src.b[k*BLOCK +: BLOCK]),
      .cin_i (src.c),
      .sum_o (gsum),
      .cout_o(gco),
      .cmsb_o(gcm)
    );

    // Only the last stage's overflow reaches the port.
    always_comb begin
      d                        = src;
      d.s[k*BLOCK +: BLOCK]    = gsum;
      d.c                      = gco;
      d.ovf                    = gcm ^ gco;
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        r <= '0;
      end else if (adv) begin
        r <= d;
      end
    end

    assign q[k] = r;
  end

  logic unused_ops;
  assign unused_ops = ^{q[S-1].a, q[S-1].b};

  assign OutValid    = q[S-1].v;
  assign Sum         = q[S-1].s;
  assign OutputCarry = q[S-1].c;
  assign Overflow    = q[S-1].ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder.
// Uses an 8/4 instance and a 32/8 instance.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic       iv8 = 0, ir8, ov8, or8 = 1;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic       ci8 = 0, sub8 = 0, co8, of8;

  logic        iv32 = 0, ir32, ov32, or32 = 1;
  logic [31:0] a32 = 0, b32 = 0, s32;
  logic        ci32 = 0, sub32 = 0, co32, of32;

  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4)) u_d8 (
    .Clk(clk), .Reset(rst_n),
    .InValid(iv8), .InReady(ir8),
    .InputA(a8), .InputB(b8),
    .InputCarry(ci8), .Subtract(sub8),
    .OutValid(ov8), .OutReady(or8),
    .Sum(s8), .OutputCarry(co8), .Overflow(of8)
  );

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_d32 (
    .Clk(clk), .Reset(rst_n),
    .InValid(iv32), .InReady(ir32),
    .InputA(a32), .InputB(b32),
    .InputCarry(ci32), .Subtract(sub32),
    .OutValid(ov32), .OutReady(or32),
    .Sum(s32), .OutputCarry(co32), .Overflow(of32)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ov8, s8, co8, of8, ir8} !== {1'b0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset8 got v=%b s=%0d c=%b o=%b r=%b want 0 0 0 0 1",
               ov8, s8, co8, of8, ir8);
    end
    checks++;
    if ({ov32, s32, co32, of32, ir32} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset32 got v=%b s=%0d c=%b o=%b r=%b want 0 0 0 0 1",
               ov32, s32, co32, of32, ir32);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add8;
    logic [7:0] ta [3] = '{8'd5, 8'd255, 8'd127};
    logic [7:0] tb [3] = '{8'd12, 8'd1, 8'd1};
    logic [7:0] es [3] = '{8'd17, 8'd0, 8'd128};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      iv8 = 1; a8 = ta[i]; b8 = tb[i]; ci8 = 0; sub8 = 0;
      lat = 0;
      do begin
        @(negedge clk);
        iv8 = 0;
        lat++;
      end while (!ov8 && lat < 8);
      checks++;
      if (lat !== 2 || ov8 !== 1'b1) begin
        errors++;
        $display("FAIL add8_lat[%0d] got %0d want 2", i, lat);
      end
      checks++;
      if ({s8, co8, of8} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL add8[%0d] got s=%0d c=%b o=%b want s=%0d c=%b o=%b",
                 i, s8, co8, of8, es[i], ec[i], eo[i]);
      end
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("FAIL add8_once[%0d] got v=%b want 0", i, ov8);
      end
    end
  endtask

  task automatic test_sub8;
    logic [7:0] ta [3] = '{8'd5, 8'h80, 8'd5};
    logic [7:0] tb [3] = '{8'd12, 8'd1, 8'd12};
    logic       tc [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] es [3] = '{8'd249, 8'd127, 8'd248};
    logic       ec [3] = '{1'b0, 1'b1, 1'b0};
    logic       eo [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      iv8 = 1; a8 = ta[i]; b8 = tb[i]; ci8 = tc[i]; sub8 = 1;
      lat = 0;
      do begin
        @(negedge clk);
        iv8 = 0;
        lat++;
      end while (!ov8 && lat < 8);
      checks++;
      if (lat !== 2 || {s8, co8, of8} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL sub8[%0d] got lat=%0d s=%0d c=%b o=%b want lat=2 s=%0d c=%b o=%b",
                 i, lat, s8, co8, of8, es[i], ec[i], eo[i]);
      end
      @(negedge clk);
    end
    sub8 = 0; ci8 = 0;
  endtask

  task automatic test_back_to_back;
    int got;
    logic [31:0] es;
    logic ec;
    got = 0;
    or32 = 1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (ov32 !== (c >= 4 && c <= 14)) begin
        errors++;
        $display("FAIL b2b_valid[c%0d] got %b want %b", c, ov32,
                 (c >= 4 && c <= 14));
      end
      if (ov32) begin
        es = (got < 10) ? 32'(1001 * got) : 32'd0;
        ec = (got == 10);
        checks++;
        if (s32 !== es || co32 !== ec) begin
          errors++;
          $display("FAIL b2b_data[%0d] got s=%0d c=%b want s=%0d c=%b",
                   got, s32, co32, es, ec);
        end
        got++;
      end
      if (c < 10) begin
        iv32 = 1; a32 = 32'(c); b32 = 32'(1000 * c);
      end else if (c == 10) begin
        iv32 = 1; a32 = 32'hFFFF_FFFF; b32 = 32'd1;
      end else begin
        iv32 = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (got !== 11) begin
      errors++;
      $display("FAIL b2b_count got %0d want 11", got);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ta [3] = '{32'd7, 32'd100, 32'h8000_0000};
    logic [31:0] tb [3] = '{32'd3, 32'd200, 32'h8000_0000};
    logic [31:0] es [3] = '{32'd10, 32'd300, 32'd0};
    logic        ec [3] = '{1'b0, 1'b0, 1'b1};
    logic        eo [3] = '{1'b0, 1'b0, 1'b1};
    int got;
    got = 0;
    for (int c = 0; c < 15; c++) begin
      or32 = !(c >= 4 && c <= 6);
      if (c < 3) begin
        iv32 = 1; a32 = ta[c]; b32 = tb[c];
      end else begin
        iv32 = 0;
      end
      #1;
      if (c >= 4 && c <= 6) begin
        checks++;
        if (ov32 !== 1'b1 || ir32 !== 1'b0 || s32 !== es[0]) begin
          errors++;
          $display("FAIL stall[c%0d] got v=%b r=%b s=%0d want 1 0 %0d",
                   c, ov32, ir32, s32, es[0]);
        end
      end
      if (ov32 && or32) begin
        checks++;
        if (got >= 3 || {s32, co32, of32} !== {es[got], ec[got], eo[got]}) begin
          errors++;
          $display("FAIL drain[%0d] got s=%0d c=%b o=%b", got, s32, co32, of32);
        end
        got++;
      end
      @(negedge clk);
    end
    or32 = 1;
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL drain_count got %0d want 3", got);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] ta [3] = '{32'h8000_0000, 32'd1, 32'd2};
    logic [31:0] tb [3] = '{32'hFFFF_FFFF, 32'd1, 32'd2};
    int stale;
    int lat;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        iv32 = 1; a32 = ta[c]; b32 = tb[c];
      end else begin
        iv32 = 0;
      end
      @(negedge clk);
    end
    checks++;
    if ({ov32, s32, co32, of32} !== {1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_rst got v=%b s=%h c=%b o=%b want 1 7fffffff 1 1",
               ov32, s32, co32, of32);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov32, s32, co32, of32, ir32} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_rst got v=%b s=%h c=%b o=%b r=%b want 0 0 0 0 1",
               ov32, s32, co32, of32, ir32);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov32) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL stale_valid got %0d want 0", stale);
    end
    iv32 = 1; a32 = 32'd1234; b32 = 32'd4321;
    lat = 0;
    do begin
      @(negedge clk);
      iv32 = 0;
      lat++;
    end while (!ov32 && lat < 12);
    checks++;
    if (lat !== 4 || s32 !== 32'd5555 || co32 !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got lat=%0d s=%0d c=%b want 4 5555 0",
               lat, s32, co32);
    end
  endtask

  initial begin
    test_reset();
    test_add8();
    test_sub8();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
